// File: rtl/cmp_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Number of digit steps needed to walk a WIDTH-bit operand DIGIT bits at a time.
    function automatic int cmp_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width for the step index; a single-step operand still needs one bit.
    function automatic int cmp_cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational compare of one DIGIT-bit slice of the two operands.
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    assign lt = (a < b);
    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Digit-serial MSB-first magnitude comparator with valid/ready on both sides.
// Define CMP_EARLY_EXIT_EN to finish as soon as the first differing digit is seen.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CMP   | walking digits MSB-first, first difference latches lt/gt
// DONE  | result held on lt/gt/eq until out_ready
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int STEPS = cmp_steps(WIDTH, DIGIT);
    localparam int CNT_W = cmp_cnt_width(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("seq_mag_comparator: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    cmp_state_t       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CNT_W-1:0] step;
    logic             dig_lt;
    logic             dig_gt;
    logic             dig_eq;
    logic             decided;
    logic             last_step;
    logic             finish;

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (sh_a[WIDTH-1 -: DIGIT]),
        .b  (sh_b[WIDTH-1 -: DIGIT]),
        .lt (dig_lt),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign decided   = lt || gt;
    assign last_step = (step == LAST_STEP);

`ifdef CMP_EARLY_EXIT_EN
    assign finish = last_step || (!decided && !dig_eq);
`else
    assign finish = last_step;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            step  <= '0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Flipping both sign bits maps two's-complement order onto unsigned order.
                        sh_a  <= signed_mode ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
                        sh_b  <= signed_mode ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;
                        step  <= '0;
                        lt    <= 1'b0;
                        gt    <= 1'b0;
                        eq    <= 1'b0;
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (!decided) begin
                        lt <= dig_lt;
                        gt <= dig_gt;
                    end
                    sh_a <= sh_a << DIGIT;
                    sh_b <= sh_b << DIGIT;
                    step <= step + 1'b1;
                    if (finish) begin
                        eq    <= !(decided || dig_lt || dig_gt);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator (WIDTH=8, DIGIT=2); follows CMP_EARLY_EXIT_EN for latency.
module tb_seq_mag_comparator;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int STEPS = 4;
`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             signed_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             lt, gt, eq;

    seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .lt          (lt),
        .gt          (gt),
        .eq          (eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] res;
        int         acc;
        int         lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   fresh = 1'b1;
    bit   rand_stall = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_stall) out_ready = 1'($urandom_range(0, 1));
    end

    function automatic logic [2:0] model_res(input logic [7:0] ia, input logic [7:0] ib, input logic sm);
        if (sm) begin
            if ($signed(ia) < $signed(ib)) return R_LT;
            if ($signed(ia) > $signed(ib)) return R_GT;
        end else begin
            if (ia < ib) return R_LT;
            if (ia > ib) return R_GT;
        end
        return R_EQ;
    endfunction

    function automatic int model_lat(input logic [7:0] ia, input logic [7:0] ib, input logic sm);
        logic [7:0] xa;
        logic [7:0] xb;
        xa = sm ? (ia ^ 8'h80) : ia;
        xb = sm ? (ib ^ 8'h80) : ib;
        for (int k = 0; k < STEPS; k++) begin
            if (xa[7-2*k -: 2] != xb[7-2*k -: 2]) return EARLY ? k + 1 : STEPS;
        end
        return STEPS;
    endfunction

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            fresh = 1'b1;
        end else if (out_valid) begin
            checks++;
            if ($countones({lt, gt, eq}) != 1) begin
                errors++;
                $display("FAIL onehot: got lt/gt/eq=%b, need exactly one high", {lt, gt, eq});
            end
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got lt/gt/eq=%b at cycle %0d, need no result", {lt, gt, eq}, cyc);
            end else begin
                if ({lt, gt, eq} != q[0].res) begin
                    errors++;
                    $display("FAIL result: got lt/gt/eq=%b, need %b", {lt, gt, eq}, q[0].res);
                end
                if (fresh) begin
                    checks++;
                    if (cyc - q[0].acc != q[0].lat) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, need %0d", cyc - q[0].acc, q[0].lat);
                    end
                    fresh = 1'b0;
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    fresh = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic sm,
                         input logic [2:0] res, input int lat, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        a = ia;
        b = ib;
        signed_mode = sm;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, need 1", n);
            in_valid = 1'b0;
            return;
        end
        if (push) q.push_back('{res, cyc + 1, lat});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results pending, need 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, need %b", name, got, want);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [2:0] res;
        int         lat_early;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 1'b0, R_EQ, 4};
        vecs[1] = '{8'h80, 8'h7F, 1'b0, R_GT, 1};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, R_LT, 1};
        vecs[3] = '{8'hFF, 8'hFE, 1'b1, R_GT, 4};
        vecs[4] = '{8'h00, 8'hFF, 1'b0, R_LT, 1};
        vecs[5] = '{8'h7F, 8'h80, 1'b1, R_GT, 1};
        vecs[6] = '{8'h03, 8'h02, 1'b0, R_GT, 4};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, R_EQ, 4};
        vecs[8] = '{8'h0C, 8'h08, 1'b0, R_GT, 3};
        vecs[9] = '{8'h80, 8'h00, 1'b1, R_LT, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_lt", lt, 1'b0);
        check_bit("rst_gt", gt, 1'b0);
        check_bit("rst_eq", eq, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_bit("idle_in_ready", in_ready, 1'b1);

        // Directed vectors
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res,
                  EARLY ? vecs[i].lat_early : STEPS, 1'b1);
        end
        drain(50);

        // Consumer stall in DONE while a new op is offered
        out_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, R_LT, EARLY ? 2 : STEPS, 1'b1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check_bit("stall_out_valid", out_valid, 1'b1);
        fork
            issue(8'h55, 8'h54, 1'b0, R_GT, STEPS, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_bit("stall_in_ready", in_ready, 1'b0);
                    check_bit("stall_held_valid", out_valid, 1'b1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(50);

        // Reset mid-compare drops the operation
        issue(8'hA5, 8'hA5, 1'b0, R_EQ, STEPS, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_lt", lt, 1'b0);
        check_bit("midrst_gt", gt, 1'b0);
        check_bit("midrst_eq", eq, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_bit("postrst_in_ready", in_ready, 1'b1);
        repeat (STEPS + 2) @(negedge clk);
        check_bit("postrst_no_result", out_valid, 1'b0);

        // Random operations with random consumer stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 500; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rs;
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? ra : 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, model_res(ra, rb, rs), model_lat(ra, rb, rs), 1'b1);
        end
        drain(200);
        rand_stall = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
